// File: rtl/iod_dly_pkg.sv
// Shared types and constants for the IOD delay-line step controller.
// Holds the op encodings, the FSM state enum and the per-step cycle cost.
package iod_dly_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIR    = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;

  // One pulse cycle followed by the settle window.
  function automatic int unsigned step_cycles(input int unsigned settle);
    return settle + 1;
  endfunction

  localparam int unsigned STEP_CYCLES_DEFAULT = step_cycles(SETTLE_CYCLES_DEFAULT);

endpackage

// File: rtl/iod_dly_step_ctrl_if.sv
// Command/status bus between a requester and the IOD delay step controller.
interface iod_dly_step_ctrl_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_OP;
  logic [7:0] REQ_STEPS;
  logic       DONE;
  logic       ERR;
  logic [7:0] TAP;
  logic       TAP_VALID;

  modport master (
    output REQ_VALID, REQ_OP, REQ_STEPS,
    input  REQ_READY, DONE, ERR, TAP, TAP_VALID
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_STEPS,
    output REQ_READY, DONE, ERR, TAP, TAP_VALID
  );
endinterface

// File: rtl/iod_dly_settle_tmr.sv
// Settle-window down-counter: start_i loads SETTLE_CYCLES, last_o flags the
// final settle cycle, which is where the IOD range flag is sampled.
module iod_dly_settle_tmr #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic last_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else if (start_i) begin
      cnt_q <= 4'(SETTLE_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/iod_dly_step_ctrl.sv
// IOD delay-line step controller: sequences LOAD and INC/DEC commands into
// single-cycle IOD pulses with settle gaps, tracking the tap count.
module iod_dly_step_ctrl
  import iod_dly_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  LOAD_VAL      = 8'd1,
  parameter logic [7:0]  TAP_MAX       = 8'd255
) (
  input  logic                  FAB_CLK,
  input  logic                  SYNC_RST,
  iod_dly_step_ctrl_if.slave    bus,
  output logic                  DELAY_LINE_LOAD,
  output logic                  DELAY_LINE_MOVE,
  output logic                  DELAY_LINE_DIRECTION,
  input  logic                  DELAY_LINE_OUT_OF_RANGE
);

  state_e     state_q;
  op_e        op_q;
  logic [7:0] steps_q;
  logic [7:0] tap_q;
  logic       tap_valid_q;
  logic       ready_q;
  logic       done_q;
  logic       err_q;
  logic       load_q;
  logic       move_q;
  logic       dir_q;
  logic       settle_last_s;
  logic       at_limit_s;
  op_e        req_op_s;

  iod_dly_settle_tmr #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_tmr (
    .clk_i   (FAB_CLK),
    .rst_i   (SYNC_RST),
    .start_i (state_q == ST_PULSE),
    .last_o  (settle_last_s)
  );

  assign req_op_s   = op_e'(bus.REQ_OP);
  assign at_limit_s = dir_q ? (tap_q == TAP_MAX) : (tap_q == 8'd0);

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      steps_q     <= 8'd0;
      tap_q       <= LOAD_VAL;
      tap_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
      move_q      <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      move_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.REQ_VALID) begin
            op_q    <= req_op_s;
            steps_q <= bus.REQ_STEPS;
            ready_q <= 1'b0;
            case (req_op_s)
              OP_LOAD: begin
                state_q     <= ST_PULSE;
                load_q      <= 1'b1;
                tap_q       <= LOAD_VAL;
                tap_valid_q <= 1'b1;
              end
              OP_INC, OP_DEC: begin
                if (tap_valid_q) begin
                  state_q <= ST_DIR;
                  dir_q   <= (req_op_s == OP_INC);
                end else begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                end
              end
              default: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end else begin
            state_q <= ST_IDLE;
          end
        end
        // DIR and the last SETTLE cycle share the "next step" decision.
        ST_DIR, ST_SETTLE: begin
          if ((state_q == ST_DIR) || settle_last_s) begin
            if ((state_q == ST_SETTLE) && (op_q == OP_LOAD)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if ((state_q == ST_SETTLE) && DELAY_LINE_OUT_OF_RANGE) begin
              tap_q   <= dir_q ? (tap_q - 8'd1) : (tap_q + 8'd1);
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (steps_q == 8'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (at_limit_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_PULSE;
              move_q  <= 1'b1;
              steps_q <= steps_q - 8'd1;
              tap_q   <= dir_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
            end
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_PULSE: begin
          state_q <= ST_SETTLE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.REQ_READY        = ready_q;
  assign bus.DONE             = done_q;
  assign bus.ERR              = err_q;
  assign bus.TAP              = tap_q;
  assign bus.TAP_VALID        = tap_valid_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_iod_dly_step_ctrl.sv
// Self-checking bench for iod_dly_step_ctrl: directed and random commands
// compared against a cycle-count model of the command rules.
module tb_iod_dly_step_ctrl;

  localparam int         S        = 4;
  localparam logic [7:0] LOAD_VAL = 8'd1;
  localparam int         TAP_MAX  = 255;
  localparam int         BOUND    = 2 + 256 * (S + 1) + 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dl_load, dl_move, dl_dir;
  logic dl_oor = 1'b0;

  int checks   = 0;
  int failures = 0;
  int model_tap   = 1;
  bit model_valid = 1'b0;

  iod_dly_step_ctrl_if bus();

  iod_dly_step_ctrl #(
    .SETTLE_CYCLES (S),
    .LOAD_VAL      (LOAD_VAL),
    .TAP_MAX       (8'd255)
  ) dut (
    .FAB_CLK                 (clk),
    .SYNC_RST                (rst),
    .bus                     (bus),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE (dl_oor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_tap   = LOAD_VAL;
    model_valid = 1'b0;
  endtask

  // Issue one command (accepted = cycle 0) and compare the observed pulse
  // timeline against the command rules.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] steps,
                         input int oor_step, input string tag);
    int exp_moves[$];
    int obs_moves[$];
    int exp_done, exp_err, exp_load_n, exp_load_cyc, t;
    int load_n, load_cyc, done_cyc, err_obs, both_bad, err_bad, dir_bad, rdy_bad;
    bit dirchk, exp_dir, seen;

    exp_err = 0; exp_load_n = 0; exp_load_cyc = 0; dirchk = 1'b0;
    exp_dir = (op == 2'b01);
    if (op == 2'b00) begin
      exp_load_n = 1; exp_load_cyc = 1; exp_done = S + 2;
      model_tap = LOAD_VAL; model_valid = 1'b1;
    end else if (op == 2'b11 || !model_valid) begin
      exp_done = 1; exp_err = 1;
    end else begin
      dirchk = 1'b1;
      t = model_tap;
      for (int i = 1; i <= int'(steps); i++) begin
        if ((exp_dir && t == TAP_MAX) || (!exp_dir && t == 0)) begin
          exp_err = 1;
          break;
        end
        t = exp_dir ? t + 1 : t - 1;
        exp_moves.push_back(2 + (i - 1) * (S + 1));
        if (i == oor_step) begin
          t = exp_dir ? t - 1 : t + 1;
          exp_err = 1;
          break;
        end
      end
      exp_done = 2 + exp_moves.size() * (S + 1);
      model_tap = t;
    end

    @(negedge clk);
    chk({tag, ":ready_before"}, {31'd0, bus.REQ_READY}, 32'd1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = op;
    bus.REQ_STEPS = steps;
    seen = 1'b0; load_n = 0; load_cyc = 0; done_cyc = -1; err_obs = 0;
    both_bad = 0; err_bad = 0; dir_bad = 0; rdy_bad = 0;
    for (int c = 1; c <= BOUND && !seen; c++) begin
      @(negedge clk);
      bus.REQ_OP    = 2'($urandom);
      bus.REQ_STEPS = 8'($urandom);
      if (dl_load) begin load_n++; load_cyc = c; end
      if (dl_move) obs_moves.push_back(c);
      if (dl_load && dl_move) both_bad++;
      if (bus.ERR && !bus.DONE) err_bad++;
      if (bus.REQ_READY) rdy_bad++;
      if (dirchk && dl_dir !== exp_dir) dir_bad++;
      if (bus.DONE) begin
        seen = 1'b1; done_cyc = c; err_obs = int'(bus.ERR);
        bus.REQ_VALID = 1'b0;
      end
      dl_oor = (oor_step != 0) && (obs_moves.size() == oor_step);
    end
    bus.REQ_VALID = 1'b0;
    dl_oor = 1'b0;

    chk({tag, ":done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, ":done_cycle"}, done_cyc, exp_done);
    chk({tag, ":err"}, err_obs, exp_err);
    chk({tag, ":load_count"}, load_n, exp_load_n);
    chk({tag, ":load_cycle"}, load_cyc, exp_load_cyc);
    chk({tag, ":move_count"}, obs_moves.size(), exp_moves.size());
    for (int i = 0; i < obs_moves.size() && i < exp_moves.size(); i++)
      chk($sformatf("%s:move%0d_cycle", tag, i), obs_moves[i], exp_moves[i]);
    chk({tag, ":load_and_move"}, both_bad, 0);
    chk({tag, ":err_without_done"}, err_bad, 0);
    chk({tag, ":dir_hold"}, dir_bad, 0);
    chk({tag, ":ready_while_busy"}, rdy_bad, 0);
    chk({tag, ":tap"}, {24'd0, bus.TAP}, model_tap);
    chk({tag, ":tap_valid"}, {31'd0, bus.TAP_VALID}, {31'd0, model_valid});

    @(negedge clk);
    chk({tag, ":done_one_cycle"}, {31'd0, bus.DONE}, 32'd0);
    chk({tag, ":err_idle"}, {31'd0, bus.ERR}, 32'd0);
    chk({tag, ":ready_after"}, {31'd0, bus.REQ_READY}, 32'd1);
  endtask

  initial begin
    int mv, post_bad;
    bus.REQ_VALID = 1'b0;
    bus.REQ_OP    = 2'b00;
    bus.REQ_STEPS = 8'd0;

    do_reset();
    chk("rst:ready", {31'd0, bus.REQ_READY}, 32'd1);
    chk("rst:done", {31'd0, bus.DONE}, 32'd0);
    chk("rst:err", {31'd0, bus.ERR}, 32'd0);
    chk("rst:load", {31'd0, dl_load}, 32'd0);
    chk("rst:move", {31'd0, dl_move}, 32'd0);
    chk("rst:dir", {31'd0, dl_dir}, 32'd0);
    chk("rst:tap", {24'd0, bus.TAP}, 32'd1);
    chk("rst:tap_valid", {31'd0, bus.TAP_VALID}, 32'd0);

    run_cmd(2'b01, 8'd3, 0, "inc_no_load");
    run_cmd(2'b11, 8'd2, 0, "reserved_op");
    run_cmd(2'b00, 8'd7, 0, "load");
    run_cmd(2'b01, 8'd3, 0, "inc3");
    run_cmd(2'b10, 8'd3, 0, "dec3");
    run_cmd(2'b10, 8'd5, 0, "dec5_floor");
    run_cmd(2'b01, 8'd0, 0, "inc0_at_floor");
    run_cmd(2'b00, 8'd0, 0, "reload");
    run_cmd(2'b01, 8'd4, 2, "inc4_oor2");
    run_cmd(2'b01, 8'd255, 0, "inc255_ceiling");
    run_cmd(2'b01, 8'd1, 0, "inc_at_max");
    run_cmd(2'b10, 8'd2, 1, "dec2_oor1");
    run_cmd(2'b10, 8'd0, 0, "dec0");

    for (int k = 0; k < 24; k++) begin
      logic [1:0] rop;
      logic [7:0] rsteps;
      int roor;
      rop    = 2'($urandom_range(0, 3));
      rsteps = 8'($urandom_range(0, 6));
      roor   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_cmd(rop, rsteps, roor, $sformatf("rand%0d", k));
    end

    // Reset in the middle of an INC 3 (accepted cycle 0, reset sampled at end of cycle 8).
    run_cmd(2'b00, 8'd0, 0, "load_before_abort");
    @(negedge clk);
    bus.REQ_VALID = 1'b1;
    bus.REQ_OP    = 2'b01;
    bus.REQ_STEPS = 8'd3;
    mv = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      if (dl_move) mv++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_tap = LOAD_VAL;
    model_valid = 1'b0;
    chk("abort:moves_before", mv, 2);
    chk("abort:ready", {31'd0, bus.REQ_READY}, 32'd1);
    chk("abort:tap", {24'd0, bus.TAP}, 32'd1);
    chk("abort:tap_valid", {31'd0, bus.TAP_VALID}, 32'd0);
    post_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (dl_move || dl_load || bus.DONE || !bus.REQ_READY) post_bad++;
      @(negedge clk);
    end
    chk("abort:quiet_after", post_bad, 0);
    run_cmd(2'b10, 8'd1, 0, "dec_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
